// File: rtl/aes_cmd_pkg.sv
// Shared opcode enum, register-window offsets and decode helper for the AES
// command decoder and its consumers.
package aes_cmd_pkg;

    typedef enum logic [3:0] {
        OP_NONE          = 4'd0,
        OP_WRITE_ADDRESS = 4'd1,
        OP_START_ENCRYPT = 4'd2,
        OP_READ_LENGTH   = 4'd3,
        OP_READ_ADDRESS  = 4'd4,
        OP_READ_KEY      = 4'd5,
        OP_READ_COUNTER  = 4'd6,
        OP_GET_STATUS    = 4'd7,
        OP_WRITE_LENGTH  = 4'd8,
        OP_WRITE_KEY     = 4'd9,
        OP_WRITE_COUNTER = 4'd10
    } aes_op_e;

    localparam logic [5:0] OFF_START = 6'h00;
    localparam logic [5:0] OFF_ADDR  = 6'h02;
    localparam logic [5:0] OFF_LEN   = 6'h04;
    localparam logic [5:0] OFF_KEY   = 6'h10;
    localparam logic [5:0] OFF_CTR   = 6'h20;
    localparam logic [5:0] OFF_END   = 6'h30;

    typedef struct packed {
        aes_op_e    op;
        logic [5:0] off;
    } cmd_hdr_t;

    // Classifies an in-window offset; OP_NONE marks an illegal access.
    function automatic aes_op_e decode_op(input logic wr, input logic [5:0] off,
                                          input logic data_one);
        aes_op_e op;
        op = OP_NONE;
        if (off == OFF_START)
            op = wr ? (data_one ? OP_START_ENCRYPT : OP_NONE) : OP_GET_STATUS;
        else if (off[5:1] == OFF_ADDR[5:1])
            op = wr ? OP_WRITE_ADDRESS : OP_READ_ADDRESS;
        else if (off[5:1] == OFF_LEN[5:1])
            op = wr ? OP_WRITE_LENGTH : OP_READ_LENGTH;
        else if (off[5:4] == OFF_KEY[5:4])
            op = wr ? OP_WRITE_KEY : OP_READ_KEY;
        else if (off[5:4] == OFF_CTR[5:4])
            op = wr ? OP_WRITE_COUNTER : OP_READ_COUNTER;
        return op;
    endfunction

endpackage

// File: rtl/aes_cmd_fifo.sv
// Generic DEPTH x W synchronous FIFO with a registered head entry and
// registered full/valid flags; asynchronous active-low reset.
module aes_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic         full,
    output logic         valid,
    output logic [W-1:0] dout
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
    logic [AW:0]   count_reg, count_next;
    logic          full_reg, valid_reg;
    logic [W-1:0]  dout_reg, dout_next;
    logic          push_ok, pop_ok;

    assign push_ok = push && !full_reg;
    assign pop_ok  = pop && valid_reg;

    always_comb begin
        count_next  = count_reg;
        rd_ptr_next = rd_ptr_reg + AW'(pop_ok);
        dout_next   = dout_reg;
        if (push_ok && !pop_ok)
            count_next = count_reg + (AW+1)'(1);
        else if (!push_ok && pop_ok)
            count_next = count_reg - (AW+1)'(1);
        // The new head is the entry being written now only when the memory
        // holds nothing else after this cycle's pop.
        if (count_next != '0) begin
            if (push_ok && (count_reg == (AW+1)'(pop_ok)))
                dout_next = din;
            else
                dout_next = mem[rd_ptr_next];
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr_reg] <= din;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            full_reg   <= 1'b0;
            valid_reg  <= 1'b0;
            dout_reg   <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_reg + AW'(push_ok);
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            full_reg   <= (count_next == (AW+1)'(DEPTH));
            valid_reg  <= (count_next != '0);
            dout_reg   <= dout_next;
        end
    end

    assign full  = full_reg;
    assign valid = valid_reg;
    assign dout  = dout_reg;

endmodule

// File: rtl/aes_cmd_decode_q.sv
// AES MMIO instruction decoder with command FIFO and illegal-access counter.
// Define AES_CMD_DECODE_BYPASS_EN for zero-latency presentation on an empty FIFO.
module aes_cmd_decode_q
    import aes_cmd_pkg::*;
#(
    parameter int                ADDR_W = 16,
    parameter int                DATA_W = 8,
    parameter logic [ADDR_W-1:0] BASE   = 16'hFF00,
    parameter int                DEPTH  = 4,
    parameter int                ERR_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stb,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic              stall,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output aes_op_e           cmd_op,
    output logic [5:0]        cmd_off,
    output logic [DATA_W-1:0] cmd_data,
    output logic [ERR_W-1:0]  err_cnt,
    output logic              err_sticky,
    input  logic              err_clr
);
    localparam int FW = $bits(cmd_hdr_t) + DATA_W;

    logic [ADDR_W-1:0] off_full;
    logic              in_window;
    aes_op_e           dec_op;
    logic              accept, push, illegal;
    logic [FW-1:0]     entry, fifo_dout;
    logic              fifo_push, fifo_full, fifo_valid;
    cmd_hdr_t          head_hdr;
    logic [ERR_W-1:0]  err_cnt_reg;
    logic              err_sticky_reg;

    // Subtraction wraps for addresses below BASE, so both bounds are checked.
    assign off_full  = addr - BASE;
    assign in_window = (addr >= BASE) && (off_full < ADDR_W'(OFF_END));
    assign dec_op    = in_window ? decode_op(wr, off_full[5:0], data_in == DATA_W'(1))
                                 : OP_NONE;

    assign accept  = stb && !stall;
    assign push    = accept && (dec_op != OP_NONE);
    assign illegal = accept && (dec_op == OP_NONE);
    assign entry   = {dec_op, off_full[5:0], (wr ? data_in : {DATA_W{1'b0}})};

    aes_cmd_fifo #(
        .DEPTH (DEPTH),
        .W     (FW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   (entry),
        .pop   (cmd_ready),
        .full  (fifo_full),
        .valid (fifo_valid),
        .dout  (fifo_dout)
    );

    assign stall    = fifo_full;
    assign head_hdr = fifo_dout[FW-1:DATA_W];

`ifdef AES_CMD_DECODE_BYPASS_EN
    logic bypass;
    assign bypass    = push && !fifo_valid && cmd_ready;
    assign fifo_push = push && !bypass;
    assign cmd_valid = fifo_valid || bypass;
    assign cmd_op    = bypass ? dec_op : head_hdr.op;
    assign cmd_off   = bypass ? off_full[5:0] : head_hdr.off;
    assign cmd_data  = bypass ? entry[DATA_W-1:0] : fifo_dout[DATA_W-1:0];
`else
    assign fifo_push = push;
    assign cmd_valid = fifo_valid;
    assign cmd_op    = head_hdr.op;
    assign cmd_off   = head_hdr.off;
    assign cmd_data  = fifo_dout[DATA_W-1:0];
`endif

    // A clear coincident with an illegal access wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt_reg    <= '0;
            err_sticky_reg <= 1'b0;
        end else if (err_clr) begin
            err_cnt_reg    <= '0;
            err_sticky_reg <= 1'b0;
        end else if (illegal) begin
            if (err_cnt_reg != {ERR_W{1'b1}})
                err_cnt_reg <= err_cnt_reg + ERR_W'(1);
            err_sticky_reg <= 1'b1;
        end
    end

    assign err_cnt    = err_cnt_reg;
    assign err_sticky = err_sticky_reg;

endmodule

// File: tb/tb_aes_cmd_decode_q.sv
// Directed self-checking bench for aes_cmd_decode_q (default parameters).
module tb_aes_cmd_decode_q;
    import aes_cmd_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stb = 1'b0;
    logic        wr = 1'b0;
    logic [15:0] addr = '0;
    logic [7:0]  data_in = '0;
    logic        stall;
    logic        cmd_valid;
    logic        cmd_ready = 1'b0;
    aes_op_e     cmd_op;
    logic [5:0]  cmd_off;
    logic [7:0]  cmd_data;
    logic [7:0]  err_cnt;
    logic        err_sticky;
    logic        err_clr = 1'b0;

    int checks = 0;
    int errors = 0;

    aes_cmd_decode_q dut (
        .clk        (clk),
        .rst        (rst),
        .stb        (stb),
        .wr         (wr),
        .addr       (addr),
        .data_in    (data_in),
        .stall      (stall),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_off    (cmd_off),
        .cmd_data   (cmd_data),
        .err_cnt    (err_cnt),
        .err_sticky (err_sticky),
        .err_clr    (err_clr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_access(input logic w, input logic [15:0] a, input logic [7:0] d);
        stb = 1'b1; wr = w; addr = a; data_in = d;
        tick();
        stb = 1'b0;
        $display("bus %s addr=%h data=%h -> valid=%0b op=%0d off=%h cdata=%h stall=%0b err=%0d",
                 w ? "WR" : "RD", a, d, cmd_valid, cmd_op, cmd_off, cmd_data, stall, err_cnt);
    endtask

    task automatic test_reset();
        stb = 1'b1; wr = 1'b1; addr = 16'hFF00; data_in = 8'h01;
        repeat (3) tick();
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %0b want 0", stall); end
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", cmd_valid); end
        checks++; if (cmd_op !== OP_NONE) begin errors++; $display("FAIL reset_op got %0d want 0", cmd_op); end
        checks++; if (cmd_off !== 6'h00) begin errors++; $display("FAIL reset_off got %h want 00", cmd_off); end
        checks++; if (cmd_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", cmd_data); end
        checks++; if (err_cnt !== 8'h00) begin errors++; $display("FAIL reset_errcnt got %h want 00", err_cnt); end
        checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL reset_sticky got %0b want 0", err_sticky); end
        stb = 1'b0;
        rst = 1'b1;
        tick();
        $display("reset released");
    endtask

    task automatic test_start();
        cmd_ready = 1'b0;
        bus_access(1'b1, 16'hFF00, 8'h01);
        checks++; if (cmd_valid !== 1'b1) begin errors++; $display("FAIL start_valid got %0b want 1", cmd_valid); end
        checks++; if (cmd_op !== OP_START_ENCRYPT) begin errors++; $display("FAIL start_op got %0d want 2", cmd_op); end
        checks++; if (cmd_off !== 6'h00) begin errors++; $display("FAIL start_off got %h want 00", cmd_off); end
        checks++; if (cmd_data !== 8'h01) begin errors++; $display("FAIL start_data got %h want 01", cmd_data); end
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL start_pop_valid got %0b want 0", cmd_valid); end
        checks++; if (cmd_op !== OP_START_ENCRYPT) begin errors++; $display("FAIL start_hold_op got %0d want 2", cmd_op); end
    endtask

    task automatic test_ops();
        logic        w_t   [7];
        logic [15:0] a_t   [7];
        logic [7:0]  d_t   [7];
        logic [3:0]  op_t  [7];
        logic [5:0]  off_t [7];
        logic [7:0]  exp_d;
        w_t   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        a_t   = '{16'hFF00, 16'hFF02, 16'hFF03, 16'hFF05, 16'hFF1F, 16'hFF2F, 16'hFF10};
        d_t   = '{8'h77, 8'h5A, 8'h77, 8'h21, 8'h99, 8'hC3, 8'h01};
        op_t  = '{4'd7, 4'd1, 4'd4, 4'd8, 4'd5, 4'd10, 4'd9};
        off_t = '{6'h00, 6'h02, 6'h03, 6'h05, 6'h1F, 6'h2F, 6'h10};
        for (int i = 0; i < 7; i++) begin
            cmd_ready = 1'b0;
            bus_access(w_t[i], a_t[i], d_t[i]);
            exp_d = w_t[i] ? d_t[i] : 8'h00;
            checks++; if (cmd_valid !== 1'b1) begin errors++; $display("FAIL ops%0d_valid got %0b want 1", i, cmd_valid); end
            checks++; if (cmd_op !== op_t[i]) begin errors++; $display("FAIL ops%0d_op got %0d want %0d", i, cmd_op, op_t[i]); end
            checks++; if (cmd_off !== off_t[i]) begin errors++; $display("FAIL ops%0d_off got %h want %h", i, cmd_off, off_t[i]); end
            checks++; if (cmd_data !== exp_d) begin errors++; $display("FAIL ops%0d_data got %h want %h", i, cmd_data, exp_d); end
            cmd_ready = 1'b1;
            tick();
            cmd_ready = 1'b0;
        end
        checks++; if (err_cnt !== 8'h00) begin errors++; $display("FAIL ops_errcnt got %h want 00", err_cnt); end
    endtask

    task automatic test_fifo_full();
        logic [5:0] exp_off;
        logic [7:0] exp_d;
        cmd_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus_access(1'b1, 16'hFF10 + 16'(i), 8'hA0 + 8'(i));
            checks++; if (stall !== (i == 3)) begin errors++; $display("FAIL full%0d_stall got %0b want %0b", i, stall, (i == 3)); end
        end
        checks++; if (cmd_op !== OP_WRITE_KEY) begin errors++; $display("FAIL full_head_op got %0d want 9", cmd_op); end
        checks++; if (cmd_off !== 6'h10) begin errors++; $display("FAIL full_head_off got %h want 10", cmd_off); end
        stb = 1'b1; wr = 1'b1; addr = 16'hFF14; data_in = 8'hB4;
        tick();
        $display("bus WR addr=ff14 data=b4 held while stalled, stall=%0b err=%0d", stall, err_cnt);
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL held_stall got %0b want 1", stall); end
        checks++; if (err_cnt !== 8'h00) begin errors++; $display("FAIL held_errcnt got %h want 00", err_cnt); end
        checks++; if (cmd_off !== 6'h10) begin errors++; $display("FAIL held_off got %h want 10", cmd_off); end
        cmd_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 2) stb = 1'b0;
            exp_off = 6'(16 + k);
            exp_d   = (k == 4) ? 8'hB4 : 8'(8'hA0 + k);
            $display("pop %0d -> valid=%0b off=%h data=%h stall=%0b", k, cmd_valid, cmd_off, cmd_data, stall);
            checks++; if (cmd_valid !== 1'b1) begin errors++; $display("FAIL drain%0d_valid got %0b want 1", k, cmd_valid); end
            checks++; if (cmd_off !== exp_off) begin errors++; $display("FAIL drain%0d_off got %h want %h", k, cmd_off, exp_off); end
            checks++; if (cmd_data !== exp_d) begin errors++; $display("FAIL drain%0d_data got %h want %h", k, cmd_data, exp_d); end
            checks++; if (stall !== 1'b0) begin errors++; $display("FAIL drain%0d_stall got %0b want 0", k, stall); end
        end
        tick();
        cmd_ready = 1'b0;
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got %0b want 0", cmd_valid); end
        checks++; if (err_cnt !== 8'h00) begin errors++; $display("FAIL drain_errcnt got %h want 00", err_cnt); end
    endtask

    task automatic test_illegal();
        bus_access(1'b1, 16'hFF00, 8'h02);
        checks++; if (err_cnt !== 8'h01) begin errors++; $display("FAIL ill1_errcnt got %h want 01", err_cnt); end
        bus_access(1'b0, 16'hFF08, 8'h00);
        bus_access(1'b1, 16'hFE00, 8'h01);
        checks++; if (err_cnt !== 8'h03) begin errors++; $display("FAIL ill_errcnt got %h want 03", err_cnt); end
        checks++; if (err_sticky !== 1'b1) begin errors++; $display("FAIL ill_sticky got %0b want 1", err_sticky); end
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL ill_valid got %0b want 0", cmd_valid); end
    endtask

    task automatic test_saturate();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++; if (err_cnt !== 8'h00) begin errors++; $display("FAIL clr_errcnt got %h want 00", err_cnt); end
        checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL clr_sticky got %0b want 0", err_sticky); end
        stb = 1'b1; wr = 1'b1; addr = 16'hFE00; data_in = 8'h00;
        repeat (255) tick();
        checks++; if (err_cnt !== 8'hFF) begin errors++; $display("FAIL sat255_errcnt got %h want ff", err_cnt); end
        tick();
        stb = 1'b0;
        $display("illegal burst x256 -> err=%h sticky=%0b", err_cnt, err_sticky);
        checks++; if (err_cnt !== 8'hFF) begin errors++; $display("FAIL sat256_errcnt got %h want ff", err_cnt); end
        err_clr = 1'b1;
        bus_access(1'b1, 16'hFE00, 8'h00);
        err_clr = 1'b0;
        checks++; if (err_cnt !== 8'h00) begin errors++; $display("FAIL clrwin_errcnt got %h want 00", err_cnt); end
        checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL clrwin_sticky got %0b want 0", err_sticky); end
    endtask

    task automatic test_back_to_back();
        cmd_ready = 1'b0;
        bus_access(1'b1, 16'hFF02, 8'h33);
        bus_access(1'b0, 16'hFF04, 8'h00);
        stb = 1'b1; wr = 1'b0; addr = 16'hFF21; data_in = 8'h00;
        cmd_ready = 1'b1;
        tick();
        stb = 1'b0;
        cmd_ready = 1'b0;
        $display("push RD ff21 with pop -> op=%0d off=%h", cmd_op, cmd_off);
        checks++; if (cmd_op !== OP_READ_LENGTH) begin errors++; $display("FAIL b2b_op1 got %0d want 3", cmd_op); end
        checks++; if (cmd_off !== 6'h04) begin errors++; $display("FAIL b2b_off1 got %h want 04", cmd_off); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL b2b_stall got %0b want 0", stall); end
        cmd_ready = 1'b1;
        tick();
        checks++; if (cmd_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid2 got %0b want 1", cmd_valid); end
        checks++; if (cmd_op !== OP_READ_COUNTER) begin errors++; $display("FAIL b2b_op2 got %0d want 6", cmd_op); end
        checks++; if (cmd_off !== 6'h21) begin errors++; $display("FAIL b2b_off2 got %h want 21", cmd_off); end
        tick();
        cmd_ready = 1'b0;
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got %0b want 0", cmd_valid); end
    endtask

    task automatic test_bypass();
        cmd_ready = 1'b1;
        stb = 1'b1; wr = 1'b0; addr = 16'hFF04; data_in = 8'h55;
        #1;
`ifdef AES_CMD_DECODE_BYPASS_EN
        checks++; if (cmd_valid !== 1'b1) begin errors++; $display("FAIL byp_same_valid got %0b want 1", cmd_valid); end
        checks++; if (cmd_op !== OP_READ_LENGTH) begin errors++; $display("FAIL byp_same_op got %0d want 3", cmd_op); end
`else
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL byp_same_valid got %0b want 0", cmd_valid); end
`endif
        tick();
        stb = 1'b0;
        $display("bus RD addr=ff04 with ready -> valid=%0b op=%0d", cmd_valid, cmd_op);
`ifdef AES_CMD_DECODE_BYPASS_EN
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL byp_next_valid got %0b want 0", cmd_valid); end
`else
        checks++; if (cmd_valid !== 1'b1) begin errors++; $display("FAIL byp_next_valid got %0b want 1", cmd_valid); end
        checks++; if (cmd_op !== OP_READ_LENGTH) begin errors++; $display("FAIL byp_next_op got %0d want 3", cmd_op); end
`endif
        tick();
        cmd_ready = 1'b0;
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL byp_end_valid got %0b want 0", cmd_valid); end
    endtask

    task automatic test_reset_flush();
        cmd_ready = 1'b0;
        bus_access(1'b1, 16'hFF10, 8'h11);
        bus_access(1'b1, 16'hFF11, 8'h22);
        bus_access(1'b1, 16'hFF01, 8'h00);
        rst = 1'b0;
        #1;
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %0b want 0", cmd_valid); end
        checks++; if (cmd_op !== OP_NONE) begin errors++; $display("FAIL flush_op got %0d want 0", cmd_op); end
        checks++; if (err_cnt !== 8'h00) begin errors++; $display("FAIL flush_errcnt got %h want 00", err_cnt); end
        tick();
        rst = 1'b1;
        tick();
        $display("mid-operation reset -> valid=%0b stall=%0b", cmd_valid, stall);
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL flush_after_valid got %0b want 0", cmd_valid); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_after_stall got %0b want 0", stall); end
    endtask

    initial begin
        test_reset();
        test_start();
        test_ops();
        test_fifo_full();
        test_illegal();
        test_saturate();
        test_back_to_back();
        test_bypass();
        test_reset_flush();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
